// File: rtl/snow64_fetch_queue.sv
// snow64_fetch_queue: sequential icache fetcher feeding a DEPTH-entry instruction/PC FIFO with redirect flush
module snow64_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter bit CTRL_FLOW_STOP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         icache_req,
  output logic [ADDR_WIDTH-1:0]        icache_addr,
  input  logic                         icache_valid,
  input  logic [INSTR_WIDTH-1:0]       icache_instr,
  input  logic                         fetched_ctrl_flow,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         deq_valid,
  output logic [INSTR_WIDTH-1:0]       deq_instr,
  output logic [ADDR_WIDTH-1:0]        deq_pc,
  input  logic                         deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);
  typedef enum logic {ST_FETCH, ST_WAIT_REDIRECT} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign icache_req = (state == ST_FETCH) && (count != FULL) && !redirect_valid;
  assign icache_addr = fetch_pc;
  assign deq_valid = (count != '0) && !redirect_valid;
  assign deq_instr = mem_instr[rd_ptr];
  assign deq_pc = mem_pc[rd_ptr];
  assign push = icache_req && icache_valid;
  assign pop = deq_valid && deq_ready;
  always_comb begin
    state_next = redirect_valid ? ST_FETCH
               : (push && fetched_ctrl_flow && CTRL_FLOW_STOP) ? ST_WAIT_REDIRECT
               : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      fetch_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          mem_instr[wr_ptr] <= icache_instr;
          mem_pc[wr_ptr] <= fetch_pc;
          wr_ptr <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + STEP;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
